// File: rtl/seq_divider.sv
// Sequential repeated-subtraction divider: operands arrive on data_in_i in LD_A/LD_B, one subtraction per RUN cycle.
// Optional feature macro: SEQ_DIV_DBZ_FLAG_EN adds the div_by_zero_o flag port and its register.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
`ifdef SEQ_DIV_DBZ_FLAG_EN
  ,
  output logic             div_by_zero_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SEQ_DIV_DBZ_FLAG_EN
  logic             dbz_q, dbz_d;
`endif

  // Next-state, datapath and state-decoded output logic
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
`ifdef SEQ_DIV_DBZ_FLAG_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LD_A: begin
        r_d     = data_in_i;
        state_d = S_LD_B;
      end
      S_LD_B: begin
        d_d     = data_in_i;
        q_d     = {WIDTH{1'b0}};
`ifdef SEQ_DIV_DBZ_FLAG_EN
        dbz_d   = 1'b0;
`endif
        state_d = S_RUN;
      end
      S_RUN: begin
        // A zero divisor saturates the quotient and leaves the dividend as remainder
        if (d_q == {WIDTH{1'b0}}) begin
          q_d     = {WIDTH{1'b1}};
`ifdef SEQ_DIV_DBZ_FLAG_EN
          dbz_d   = 1'b1;
`endif
          state_d = S_DONE;
        end else if (r_q >= d_q) begin
          r_d     = r_q - d_q;
          q_d     = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_LD_A) || (state_d == S_LD_B) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_DIV_DBZ_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_DIV_DBZ_FLAG_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = q_q;
  assign remainder_o = r_q;
`ifdef SEQ_DIV_DBZ_FLAG_EN
  assign div_by_zero_o = dbz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, corner sequences and randomized runs vs. an arithmetic model.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
`ifdef SEQ_DIV_DBZ_FLAG_EN
  logic         dbz;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_q = '0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .data_in_i(data_in),
    .busy_o(busy), .done_o(done), .quotient_o(quotient), .remainder_o(remainder)
`ifdef SEQ_DIV_DBZ_FLAG_EN
    , .div_by_zero_o(dbz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           runs;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Waits for the done pulse, starting just after the LD_B edge; returns RUN cycle count.
  task automatic wait_done(input int bound, input int inj, output int n, output bit seen, output bit busy_bad);
    n = 0; seen = 1'b0; busy_bad = 1'b0;
    while (n < bound && !seen) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (!busy) busy_bad = 1'b1;
      start = (n == inj);
    end
    start = 1'b0;
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input int eruns, input int inj, input string nm);
    int n; bit seen, bb;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; data_in = a;
    chk({nm, ".busy_lda"}, busy, 1);
    @(posedge clk);
    @(negedge clk); data_in = b;
    chk({nm, ".q_hold"}, quotient, prev_q);
    chk({nm, ".r_load"}, remainder, a);
    @(posedge clk);
    @(negedge clk); data_in = W'($urandom);
`ifdef SEQ_DIV_DBZ_FLAG_EN
    chk({nm, ".dbz_clr"}, dbz, 0);
`endif
    wait_done(eruns + 20, inj, n, seen, bb);
    chk({nm, ".done_seen"}, seen, 1);
    chk({nm, ".runs"}, n, eruns);
    chk({nm, ".busy_run"}, bb, 0);
    chk({nm, ".quot"}, quotient, eq);
    chk({nm, ".rem"}, remainder, er);
    chk({nm, ".busy_done"}, busy, 0);
`ifdef SEQ_DIV_DBZ_FLAG_EN
    chk({nm, ".dbz"}, dbz, (b == '0));
`endif
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".done_pulse"}, done, 0);
    chk({nm, ".idle_after"}, busy, 0);
    chk({nm, ".q_held"}, quotient, eq);
    prev_q = eq;
  endtask

  vec_t tbl[6];

  initial begin
    int n; bit seen, bb;
    logic [W-1:0] a, b, eq, er;
    int qt;

    tbl[0] = '{a: 16'd100, b: 16'd7, q: 16'd14,     r: 16'd2, runs: 15};
    tbl[1] = '{a: 16'd0,   b: 16'd5, q: 16'd0,      r: 16'd0, runs: 1};
    tbl[2] = '{a: 16'd3,   b: 16'd9, q: 16'd0,      r: 16'd3, runs: 1};
    tbl[3] = '{a: 16'd5,   b: 16'd0, q: 16'hFFFF,   r: 16'd5, runs: 1};
    tbl[4] = '{a: 16'd7,   b: 16'd7, q: 16'd1,      r: 16'd0, runs: 2};
    tbl[5] = '{a: 16'd6,   b: 16'd7, q: 16'd0,      r: 16'd6, runs: 1};

    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.busy", busy, 0);
    chk("idle.done", done, 0);
    chk("idle.quot", quotient, 0);
    chk("idle.rem", remainder, 0);

    for (int i = 0; i < 6; i++) begin
      run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].runs, -1, $sformatf("tbl%0d", i));
`ifdef SEQ_DIV_DBZ_FLAG_EN
      if (tbl[i].b == '0) begin
        repeat (3) @(negedge clk);
        chk("dbz_hold_idle", dbz, 1);
      end
`endif
    end

    // Start held high: ignored in DONE, re-triggers from the following IDLE cycle
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); data_in = 16'd9;
    @(posedge clk);
    @(negedge clk); data_in = 16'd3;
    @(posedge clk);
    n = 0; seen = 1'b0;
    while (n < 50 && !seen) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("hold.done_seen", seen, 1);
    chk("hold.runs", n, 4);
    chk("hold.quot", quotient, 3);
    @(negedge clk);
    chk("hold.idle", busy, 0);
    @(negedge clk);
    chk("hold.retrig", busy, 1);
    start = 1'b0; data_in = 16'd50;
    @(posedge clk);
    @(negedge clk); data_in = 16'd8;
    @(posedge clk);
    @(negedge clk);
    wait_done(40, -1, n, seen, bb);
    chk("hold2.runs", n, 7);
    chk("hold2.quot", quotient, 6);
    chk("hold2.rem", remainder, 2);
    prev_q = 16'd6;

    // Largest quotient, with a stray start pulse in the middle of RUN
    run_div(16'd65535, 16'd1, 16'd65535, 16'd0, 65536, 300, "big");
    repeat (3) @(negedge clk);
    chk("big.no_second_done", done, 0);
    chk("big.no_retrig", busy, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; data_in = 16'd1000;
    @(posedge clk);
    @(negedge clk); data_in = 16'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.quot", quotient, 0);
    chk("mid.rem", remainder, 0);
`ifdef SEQ_DIV_DBZ_FLAG_EN
    chk("mid.dbz", dbz, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    prev_q = '0;
    run_div(16'd20, 16'd4, 16'd5, 16'd0, 6, -1, "post_rst");

    // Randomized operands with bounded quotient, checked against plain integer division
    for (int i = 0; i < 30; i++) begin
      qt = $urandom_range(0, 100);
      b  = W'($urandom_range(1, 600));
      a  = W'(qt * int'(b) + int'($urandom_range(0, int'(b) - 1)));
      if ($urandom_range(0, 7) == 0) b = '0;
      if (b == '0) begin
        eq = 16'hFFFF; er = a;
      end else begin
        eq = a / b; er = a % b;
      end
      run_div(a, b, eq, er, (b == '0) ? 1 : int'(eq) + 1, -1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
